// File: rtl/asg_pkg.sv
// Shared types for the sweep generator: FSM state encoding and the fixed-point
// pointer type (default geometry), plus a helper that derives the pointer width.
// Latency: n/a (types only). Backpressure: n/a.
package asg_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_DATA  = ST_DATA,
        S_PAUSE = ST_PAUSE,
        S_DRAIN = ST_DRAIN
    } asg_state_t;

    // Pointer is CWM integer bits over CWF fraction bits.
    function automatic int asg_ptr_w(input int cwm, input int cwf);
        return cwm + cwf;
    endfunction

    localparam int ASG_CWM_DEF = 14;
    localparam int ASG_CWF_DEF = 16;

    typedef logic [asg_ptr_w(ASG_CWM_DEF, ASG_CWF_DEF)-1:0] asg_ptr_t;

endpackage

// File: rtl/asg_buf.sv
// Waveform table: simple dual-port RAM, 2**AW x DW, one write port, one registered read port.
// Latency: 1 cycle read; a same-address read/write returns the old word. rdata holds when ren=0.
// Ports: clk; wen/waddr/wdata write side; ren/raddr/rdata read side.
module asg_buf #(
    parameter int AW = 14,
    parameter int DW = 14
) (
    input  logic          clk,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          ren,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
        if (ren) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/asg_sweep_gen.sv
// Arbitrary signal generator engine: plays the table through a fixed-point pointer with
// trigger, burst and linear step sweep. Latency: trigger at t -> first beat at t+3.
// Backpressure: whole pipeline (pointer, counters, state, data) freezes while tvalid & ~tready.
// Ports: buf_* table write; ctl_*/trg_ext trigger and engine reset; cfg_* configuration;
// sto_* output stream; trg_out/irq_stp event pulses; sts_* status.
module asg_sweep_gen
    import asg_pkg::*;
#(
    parameter int DW  = 14,
    parameter int CWM = 14,
    parameter int CWF = 16,
    parameter int CWL = 32,
    parameter int CWN = 16,
    parameter int TN  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               buf_wen,
    input  logic [CWM-1:0]     buf_addr,
    input  logic [DW-1:0]      buf_wdata,
    input  logic               ctl_rst,
    input  logic               ctl_trg,
    input  logic [TN-1:0]      trg_ext,
    input  logic [TN-1:0]      cfg_trg,
    input  logic [CWM+CWF-1:0] cfg_siz,
    input  logic [CWM+CWF-1:0] cfg_off,
    input  logic [CWM+CWF-1:0] cfg_stp,
    input  logic [CWM+CWF-1:0] cfg_swp,
    input  logic [CWM+CWF-1:0] cfg_stm,
    input  logic               cfg_ben,
    input  logic               cfg_inf,
    input  logic [CWM-1:0]     cfg_bdl,
    input  logic [CWL-1:0]     cfg_bln,
    input  logic [CWN-1:0]     cfg_bnm,
    output logic [DW-1:0]      sto_tdata,
    output logic               sto_tvalid,
    input  logic               sto_tready,
    output logic               sto_tlast,
    output logic               trg_out,
    output logic               irq_stp,
    output logic               sts_run,
    output logic [CWL-1:0]     sts_bln,
    output logic [CWN-1:0]     sts_bnm
);

    localparam int PW = asg_ptr_w(CWM, CWF);

    asg_state_t     state, state_n;
    logic [PW-1:0]  ptr, ptr_n, stp, stp_n;
    logic [CWL-1:0] cnt_n;
    logic [CWN-1:0] bnm_n;
    logic           adv, trg_hit, issue, last_i, irq_n;
    logic           v2, h2, l2;
    logic [DW-1:0]  rdata;
    logic [PW:0]    nxt, swp_sum;
    logic [CWL:0]   cnt_inc;
    logic [CWN:0]   bnm_inc;
    logic [CWM-1:0] bdl_eff;
    logic [CWN-1:0] bnm_eff;
    logic           final_b;

    assign adv     = ~sto_tvalid | sto_tready;
    assign trg_hit = ctl_trg | (|(trg_ext & cfg_trg));
    assign sts_run = (state != S_IDLE);

    // Carry bits keep the wrap compare and the sweep saturation exact at full scale.
    assign nxt     = {1'b0, ptr} + {1'b0, stp};
    assign swp_sum = {1'b0, stp} + {1'b0, cfg_swp};
    assign cnt_inc = {1'b0, sts_bln} + (CWL+1)'(1);
    assign bnm_inc = {1'b0, sts_bnm} + (CWN+1)'(1);
    assign bdl_eff = (cfg_bdl == '0) ? CWM'(1) : cfg_bdl;
    assign bnm_eff = (cfg_bnm == '0) ? CWN'(1) : cfg_bnm;
    assign final_b = ~cfg_inf & (bnm_inc >= {1'b0, bnm_eff});

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        stp_n   = stp;
        cnt_n   = sts_bln;
        bnm_n   = sts_bnm;
        issue   = 1'b0;
        last_i  = 1'b0;
        irq_n   = 1'b0;
        trg_out = 1'b0;
        if (ctl_rst) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (trg_hit) begin
                        trg_out = 1'b1;
                        state_n = S_DATA;
                        ptr_n   = cfg_off;
                        stp_n   = cfg_stp;
                        cnt_n   = '0;
                        bnm_n   = '0;
                    end
                end
                S_DATA: begin
                    if (adv) begin
                        issue = 1'b1;
                        if (nxt >= {1'b0, cfg_siz}) begin
                            ptr_n = nxt[PW-1:0] - cfg_siz;
                            if (cfg_swp != '0) begin
                                stp_n = (swp_sum > {1'b0, cfg_stm}) ? cfg_stm : swp_sum[PW-1:0];
                            end
                        end else begin
                            ptr_n = nxt[PW-1:0];
                        end
                        if (!cfg_ben) begin
                            cnt_n = cnt_inc[CWL-1:0];
                        end else if (cnt_inc >= (CWL+1)'(bdl_eff)) begin
                            cnt_n = '0;
                            if (final_b) begin
                                last_i  = 1'b1;
                                bnm_n   = bnm_inc[CWN-1:0];
                                state_n = S_DRAIN;
                            end else if (cfg_bln == '0) begin
                                // No idle gap: next burst starts straight away from the offset.
                                bnm_n = bnm_inc[CWN-1:0];
                                ptr_n = cfg_off;
                            end else begin
                                state_n = S_PAUSE;
                            end
                        end else begin
                            cnt_n = cnt_inc[CWL-1:0];
                        end
                    end
                end
                S_PAUSE: begin
                    if (adv) begin
                        issue = 1'b1;
                        if (cnt_inc >= {1'b0, cfg_bln}) begin
                            cnt_n   = '0;
                            bnm_n   = bnm_inc[CWN-1:0];
                            ptr_n   = cfg_off;  // every burst replays from the offset
                            state_n = S_DATA;
                        end else begin
                            cnt_n = cnt_inc[CWL-1:0];
                        end
                    end
                end
                S_DRAIN: begin
                    // The tlast beat is the last thing issued, so its handshake empties the pipe.
                    if (sto_tvalid & sto_tready & sto_tlast) begin
                        state_n = S_IDLE;
                        irq_n   = 1'b1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    asg_buf #(.AW(CWM), .DW(DW)) u_buf (
        .clk   (clk),
        .wen   (buf_wen),
        .waddr (buf_addr),
        .wdata (buf_wdata),
        .ren   (adv),
        .raddr (ptr[PW-1:CWF]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            stp        <= '0;
            sts_bln    <= '0;
            sts_bnm    <= '0;
            irq_stp    <= 1'b0;
            v2         <= 1'b0;
            h2         <= 1'b0;
            l2         <= 1'b0;
            sto_tvalid <= 1'b0;
            sto_tlast  <= 1'b0;
            sto_tdata  <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            stp     <= stp_n;
            sts_bln <= cnt_n;
            sts_bnm <= bnm_n;
            irq_stp <= irq_n;
            if (ctl_rst) begin
                v2         <= 1'b0;
                sto_tvalid <= 1'b0;
                sto_tlast  <= 1'b0;
            end else if (adv) begin
                v2         <= issue;
                h2         <= (state == S_PAUSE);
                l2         <= last_i;
                sto_tvalid <= v2;
                sto_tlast  <= v2 & l2;
                // Pause beats repeat the last data sample, so only data beats load tdata.
                if (v2 & ~h2) begin
                    sto_tdata <= rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_asg_sweep_gen.sv
module tb_asg_sweep_gen;
    import asg_pkg::*;

    localparam int DW = 14, CWM = 14, CWF = 16, CWL = 32, CWN = 16, TN = 4;
    localparam int PW = CWM + CWF;

    logic clk, rst;
    logic buf_wen;
    logic [CWM-1:0] buf_addr;
    logic [DW-1:0] buf_wdata;
    logic ctl_rst, ctl_trg;
    logic [TN-1:0] trg_ext, cfg_trg;
    asg_ptr_t cfg_siz, cfg_off, cfg_stp, cfg_swp, cfg_stm;
    logic cfg_ben, cfg_inf;
    logic [CWM-1:0] cfg_bdl;
    logic [CWL-1:0] cfg_bln;
    logic [CWN-1:0] cfg_bnm;
    logic [DW-1:0] sto_tdata;
    logic sto_tvalid, sto_tready, sto_tlast, trg_out, irq_stp, sts_run;
    logic [CWL-1:0] sts_bln;
    logic [CWN-1:0] sts_bnm;

    asg_sweep_gen #(.DW(DW), .CWM(CWM), .CWF(CWF), .CWL(CWL), .CWN(CWN), .TN(TN)) dut (
        .clk(clk), .rst(rst),
        .buf_wen(buf_wen), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .ctl_rst(ctl_rst), .ctl_trg(ctl_trg), .trg_ext(trg_ext), .cfg_trg(cfg_trg),
        .cfg_siz(cfg_siz), .cfg_off(cfg_off), .cfg_stp(cfg_stp), .cfg_swp(cfg_swp),
        .cfg_stm(cfg_stm), .cfg_ben(cfg_ben), .cfg_inf(cfg_inf), .cfg_bdl(cfg_bdl),
        .cfg_bln(cfg_bln), .cfg_bnm(cfg_bnm),
        .sto_tdata(sto_tdata), .sto_tvalid(sto_tvalid), .sto_tready(sto_tready),
        .sto_tlast(sto_tlast), .trg_out(trg_out), .irq_stp(irq_stp), .sts_run(sts_run),
        .sts_bln(sts_bln), .sts_bnm(sts_bnm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] tbl [0:15];

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;
    beat_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_table(input bit rnd);
        for (int i = 0; i < 16; i++) begin
            tbl[i]    = rnd ? DW'($urandom) : DW'(i);
            buf_wen   = 1'b1;
            buf_addr  = CWM'(i);
            buf_wdata = tbl[i];
            step();
        end
        buf_wen = 1'b0;
    endtask

    // Reference: walk the burst structure directly with integer arithmetic.
    task automatic build_model(input int maxn);
        longint p, s;
        int burst, bdl_e, bnm_e;
        bit fin;
        logic [DW-1:0] last_d;
        beat_t b;
        exp_q.delete();
        p      = longint'(cfg_off);
        s      = longint'(cfg_stp);
        burst  = 0;
        last_d = '0;
        bdl_e  = (cfg_bdl == 0) ? 1 : int'(cfg_bdl);
        bnm_e  = (cfg_bnm == 0) ? 1 : int'(cfg_bnm);
        while (exp_q.size() < maxn) begin
            for (int i = 0; (!cfg_ben || i < bdl_e) && exp_q.size() < maxn; i++) begin
                last_d = tbl[int'(p >> CWF)];
                fin = cfg_ben && !cfg_inf && (burst + 1 >= bnm_e) && (i == bdl_e - 1);
                b.d = last_d;
                b.l = fin;
                exp_q.push_back(b);
                if (p + s >= longint'(cfg_siz)) begin
                    p = p + s - longint'(cfg_siz);
                    if (cfg_swp != 0) begin
                        s = (s + longint'(cfg_swp) > longint'(cfg_stm)) ? longint'(cfg_stm)
                                                                        : s + longint'(cfg_swp);
                    end
                end else begin
                    p = p + s;
                end
                if (fin) return;
            end
            burst++;
            for (int j = 0; j < int'(cfg_bln) && exp_q.size() < maxn; j++) begin
                b.d = last_d;
                b.l = 1'b0;
                exp_q.push_back(b);
            end
            p = longint'(cfg_off);
        end
    endtask

    // Pulse a trigger for one cycle; check the combinational pulse and run status afterwards.
    task automatic fire(input string tag, input bit sw, input logic [TN-1:0] ext,
                        input bit want_trg, input bit want_run);
        ctl_trg = sw;
        trg_ext = ext;
        #1;
        chk({tag, " trg_out"}, trg_out, want_trg);
        step();
        ctl_trg = 1'b0;
        trg_ext = '0;
        chk({tag, " sts_run"}, sts_run, want_run);
    endtask

    // Called at t+1 after an accepted trigger; ends at t+3.
    task automatic latency(input string tag);
        chk({tag, " tvalid t+1"}, sto_tvalid, 0);
        step();
        chk({tag, " tvalid t+2"}, sto_tvalid, 0);
        step();
        chk({tag, " tvalid t+3"}, sto_tvalid, 1);
    endtask

    // Accept n beats and compare each with the model; returns just after the n-th handshake.
    task automatic collect(input int n, input bit rnd, input string tag, output int cycles);
        int k;
        bit stalled;
        logic [DW-1:0] held;
        k = 0;
        stalled = 1'b0;
        held = '0;
        cycles = 0;
        while (k < n && cycles < 2000) begin
            sto_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (stalled) chk({tag, " stall hold"}, sto_tdata, held);
            if (sto_tvalid && sto_tready) begin
                chk($sformatf("%s beat%0d data", tag, k), sto_tdata, exp_q[k].d);
                chk($sformatf("%s beat%0d last", tag, k), sto_tlast, exp_q[k].l);
                k++;
                stalled = 1'b0;
            end else if (sto_tvalid) begin
                stalled = 1'b1;
                held = sto_tdata;
            end else begin
                stalled = 1'b0;
            end
            cycles++;
            if (k < n) step();
        end
        if (k < n) chk({tag, " beats before timeout"}, k, n);
    endtask

    task automatic stop_run();
        sto_tready = 1'b1;
        ctl_rst = 1'b1;
        step();
        ctl_rst = 1'b0;
        step();
    endtask

    task automatic cfg_cont(input logic [PW-1:0] siz, input logic [PW-1:0] off,
                            input logic [PW-1:0] stp, input logic [PW-1:0] swp,
                            input logic [PW-1:0] stm);
        cfg_siz = siz; cfg_off = off; cfg_stp = stp; cfg_swp = swp; cfg_stm = stm;
        cfg_ben = 1'b0; cfg_inf = 1'b0; cfg_bdl = '0; cfg_bln = '0; cfg_bnm = '0;
    endtask

    int cyc;

    initial begin
        rst = 1'b1;
        buf_wen = 1'b0; buf_addr = '0; buf_wdata = '0;
        ctl_rst = 1'b0; ctl_trg = 1'b0; trg_ext = '0; cfg_trg = '0;
        sto_tready = 1'b1;
        cfg_cont(PW'(8 << CWF), '0, PW'(1 << CWF), '0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst tvalid", sto_tvalid, 0);
        chk("rst tdata", sto_tdata, 0);
        chk("rst tlast", sto_tlast, 0);
        chk("rst irq", irq_stp, 0);
        chk("rst run", sts_run, 0);
        chk("rst bln", sts_bln, 0);
        chk("rst bnm", sts_bnm, 0);
        chk("rst trg_out", trg_out, 0);
        rst = 1'b0;
        step();

        write_table(1'b0);

        // Continuous playback 0..7 repeating.
        build_model(20);
        fire("cont", 1'b1, '0, 1'b1, 1'b1);
        latency("cont");
        collect(20, 1'b0, "cont", cyc);
        chk("cont no bubbles", cyc, 20);
        stop_run();
        chk("cont stopped", sts_run, 0);

        // ctl_rst with a simultaneous trigger mid-run, then restart from a new offset.
        fire("prio start", 1'b1, '0, 1'b1, 1'b1);
        repeat (6) step();
        ctl_rst = 1'b1;
        ctl_trg = 1'b1;
        #1;
        chk("prio trg_out", trg_out, 0);
        step();
        ctl_rst = 1'b0;
        ctl_trg = 1'b0;
        chk("prio tvalid", sto_tvalid, 0);
        chk("prio run", sts_run, 0);
        for (int i = 0; i < 4; i++) begin
            chk("prio irq", irq_stp, 0);
            chk("prio stays idle", sto_tvalid, 0);
            step();
        end
        cfg_off = PW'(3 << CWF);
        build_model(6);
        fire("restart", 1'b1, '0, 1'b1, 1'b1);
        latency("restart");
        collect(6, 1'b0, "restart", cyc);
        stop_run();

        // Finite burst: 0,1,2,3,3,3,0,1,2,3.
        cfg_cont(PW'(8 << CWF), '0, PW'(1 << CWF), '0, '0);
        cfg_ben = 1'b1; cfg_bdl = CWM'(4); cfg_bln = CWL'(2); cfg_bnm = CWN'(2);
        build_model(100);
        chk("burst model length", exp_q.size(), 10);
        fire("burst", 1'b1, '0, 1'b1, 1'b1);
        latency("burst");
        collect(exp_q.size(), 1'b0, "burst", cyc);
        chk("burst no bubbles", cyc, 10);
        step();
        chk("burst irq", irq_stp, 1);
        chk("burst run falls", sts_run, 0);
        chk("burst bnm", sts_bnm, 2);
        step();
        chk("burst irq pulse", irq_stp, 0);
        chk("burst drained", sto_tvalid, 0);

        // Sweep: step 1 -> 2 -> saturates at 3.
        cfg_cont(PW'(8 << CWF), '0, PW'(1 << CWF), PW'(1 << CWF), PW'(3 << CWF));
        build_model(24);
        fire("sweep", 1'b1, '0, 1'b1, 1'b1);
        latency("sweep");
        collect(24, 1'b0, "sweep", cyc);
        stop_run();

        // bdl=0 and bnm=0 behave as 1: one final beat.
        cfg_cont(PW'(8 << CWF), PW'(5 << CWF), PW'(1 << CWF), '0, '0);
        cfg_ben = 1'b1; cfg_bln = CWL'(3);
        build_model(100);
        fire("single", 1'b1, '0, 1'b1, 1'b1);
        latency("single");
        collect(exp_q.size(), 1'b0, "single", cyc);
        step();
        chk("single irq", irq_stp, 1);
        chk("single bnm", sts_bnm, 1);
        step();

        // Trigger masking.
        cfg_cont(PW'(8 << CWF), '0, PW'(1 << CWF), '0, '0);
        cfg_trg = 4'b0100;
        fire("ext2 masked in", 1'b0, 4'b0100, 1'b1, 1'b1);
        step();
        fire("retrigger ignored", 1'b1, 4'b0100, 1'b0, 1'b1);
        stop_run();
        fire("ext1 masked out", 1'b0, 4'b0010, 1'b0, 1'b0);
        cfg_trg = '0;
        fire("mask zero", 1'b0, 4'b0100, 1'b0, 1'b0);
        chk("mask zero idle", sto_tvalid, 0);

        // Infinite bursts under backpressure: never tlast.
        cfg_cont(PW'(8 << CWF), '0, PW'(1 << CWF), '0, '0);
        cfg_ben = 1'b1; cfg_inf = 1'b1; cfg_bdl = CWM'(3); cfg_bln = CWL'(1); cfg_bnm = CWN'(1);
        build_model(15);
        fire("inf", 1'b1, '0, 1'b1, 1'b1);
        latency("inf");
        collect(15, 1'b1, "inf", cyc);
        stop_run();

        // Randomised finite runs with random tready.
        for (int it = 0; it < 4; it++) begin
            write_table(1'b1);
            cfg_siz = PW'(($urandom_range(4, 15) << CWF) | $urandom_range(0, 65535));
            cfg_stp = PW'($urandom_range(1, int'(cfg_siz) - 1));
            cfg_off = PW'($urandom_range(0, int'(cfg_siz) - 1));
            cfg_swp = ($urandom_range(0, 1) == 1) ? PW'($urandom_range(1, 2 << CWF)) : '0;
            cfg_stm = PW'($urandom_range(0, int'(cfg_siz) - 1));
            cfg_ben = 1'b1; cfg_inf = 1'b0;
            cfg_bdl = CWM'($urandom_range(0, 5));
            cfg_bln = CWL'($urandom_range(0, 3));
            cfg_bnm = CWN'($urandom_range(0, 3));
            build_model(1000);
            fire($sformatf("rnd%0d", it), 1'b1, '0, 1'b1, 1'b1);
            latency($sformatf("rnd%0d", it));
            collect(exp_q.size(), 1'b1, $sformatf("rnd%0d", it), cyc);
            step();
            chk($sformatf("rnd%0d irq", it), irq_stp, 1);
            chk($sformatf("rnd%0d run falls", it), sts_run, 0);
            sto_tready = 1'b1;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
